// File: rtl/johnson_decoder_monitor_if.sv
// Johnson code link: the sequencer drives code_in/code_valid, the monitor returns
// decoded index, one-hot and health status.
interface johnson_decoder_monitor_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8
);
    localparam int unsigned N    = 2 * WIDTH;
    localparam int unsigned IdxW = $clog2(N);

    logic [WIDTH-1:0]     code_in;
    logic                 code_valid;
    logic [IdxW-1:0]      index_out;
    logic [N-1:0]         onehot_out;
    logic                 out_valid;
    logic                 code_legal;
    logic                 step_err;
    logic                 dir;
    logic                 locked;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output code_in, code_valid,
        input  index_out, onehot_out, out_valid, code_legal, step_err, dir, locked, err_count
    );

    modport slave (
        input  code_in, code_valid,
        output index_out, onehot_out, out_valid, code_legal, step_err, dir, locked, err_count
    );
endinterface

// File: rtl/johnson_decoder_monitor.sv
// Decodes a sampled Johnson code, checks that successive codes step by +/-1 (mod 2*WIDTH),
// tracks direction lock and keeps a saturating error count. All outputs registered.
module johnson_decoder_monitor #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input logic                      clk,
    input logic                      rst,
    johnson_decoder_monitor_if.slave bus
);
    localparam int unsigned N    = 2 * WIDTH;
    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

    // Index k <= WIDTH fills ones from the MSB; beyond that ones drain from the MSB.
    function automatic logic [WIDTH-1:0] johnson_code(input int unsigned k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (k <= WIDTH) return ~(ones >> k);
        return ones >> (k - WIDTH);
    endfunction

    state_e               state_q, state_d;
    logic [IdxW-1:0]      index_q, index_d;
    logic [N-1:0]         onehot_q, onehot_d;
    logic                 out_valid_q, out_valid_d;
    logic                 legal_q, legal_d;
    logic                 step_err_q, step_err_d;
    logic                 dir_q, dir_d;
    logic                 locked_q, locked_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [IdxW-1:0]      prev_idx_q, prev_idx_d;
    logic                 prev_valid_q, prev_valid_d;
    logic [CntW-1:0]      acq_cnt_q, acq_cnt_d;

    logic [IdxW-1:0] dec_idx;
    logic            dec_legal;
    logic [IdxW-1:0] idx_inc, idx_dec;
    logic            is_fwd, is_bwd, is_err, is_step;
    logic [CntW-1:0] cnt_next;

    always_comb begin
        dec_idx   = '0;
        dec_legal = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (bus.code_in == johnson_code(k)) begin
                dec_idx   = IdxW'(k);
                dec_legal = 1'b1;
            end
        end
    end

    assign idx_inc = (prev_idx_q == IdxW'(N - 1)) ? '0 : prev_idx_q + 1'b1;
    assign idx_dec = (prev_idx_q == '0) ? IdxW'(N - 1) : prev_idx_q - 1'b1;

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        onehot_d     = onehot_q;
        out_valid_d  = 1'b0;
        legal_d      = legal_q;
        step_err_d   = 1'b0;
        dir_d        = dir_q;
        locked_d     = locked_q;
        err_count_d  = err_count_q;
        prev_idx_d   = prev_idx_q;
        prev_valid_d = prev_valid_q;
        acq_cnt_d    = acq_cnt_q;
        is_fwd       = 1'b0;
        is_bwd       = 1'b0;
        is_err       = 1'b0;
        is_step      = 1'b0;
        cnt_next     = '0;

        if (bus.code_valid) begin
            out_valid_d = 1'b1;
            legal_d     = dec_legal;
            if (!dec_legal) begin
                index_d      = '0;
                onehot_d     = '0;
                is_err       = 1'b1;
                prev_valid_d = 1'b0;
            end else begin
                index_d           = dec_idx;
                onehot_d          = '0;
                onehot_d[dec_idx] = 1'b1;
                prev_idx_d        = dec_idx;
                prev_valid_d      = 1'b1;
                if (prev_valid_q) begin
                    if (dec_idx == idx_inc) is_fwd = 1'b1;
                    else if (dec_idx == idx_dec) is_bwd = 1'b1;
                    else if (dec_idx != prev_idx_q) is_err = 1'b1;
                end
            end

            is_step    = is_fwd | is_bwd;
            step_err_d = is_err;
            if (is_step) dir_d = is_fwd;
            if (is_err && err_count_q != '1) err_count_d = err_count_q + 1'b1;

            // A step continues the run only if it matches the direction of the run so far.
            if (acq_cnt_q != '0 && is_fwd == dir_q) cnt_next = acq_cnt_q + 1'b1;
            else cnt_next = CntW'(1);

            unique case (state_q)
                StUnlocked, StAcquire: begin
                    if (is_err) begin
                        state_d   = StUnlocked;
                        acq_cnt_d = '0;
                    end else begin
                        state_d = StAcquire;
                        if (is_step) begin
                            acq_cnt_d = cnt_next;
                            if (cnt_next >= CntW'(LOCK_COUNT)) state_d = StLocked;
                        end
                    end
                end
                StLocked: begin
                    if (is_err || (is_step && is_fwd != dir_q)) begin
                        state_d   = StUnlocked;
                        acq_cnt_d = '0;
                    end
                end
                default: state_d = StUnlocked;
            endcase
            locked_d = (state_d == StLocked);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StUnlocked;
            index_q      <= '0;
            onehot_q     <= '0;
            out_valid_q  <= 1'b0;
            legal_q      <= 1'b0;
            step_err_q   <= 1'b0;
            dir_q        <= 1'b1;
            locked_q     <= 1'b0;
            err_count_q  <= '0;
            prev_idx_q   <= '0;
            prev_valid_q <= 1'b0;
            acq_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            onehot_q     <= onehot_d;
            out_valid_q  <= out_valid_d;
            legal_q      <= legal_d;
            step_err_q   <= step_err_d;
            dir_q        <= dir_d;
            locked_q     <= locked_d;
            err_count_q  <= err_count_d;
            prev_idx_q   <= prev_idx_d;
            prev_valid_q <= prev_valid_d;
            acq_cnt_q    <= acq_cnt_d;
        end
    end

    assign bus.index_out  = index_q;
    assign bus.onehot_out = onehot_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.code_legal = legal_q;
    assign bus.step_err   = step_err_q;
    assign bus.dir        = dir_q;
    assign bus.locked     = locked_q;
    assign bus.err_count  = err_count_q;
endmodule
